// File: rtl/ex_shift_sequencer.sv
// Multi-cycle logical shifter for the EX stage: shifts one bit per clock and
// stalls the front of the pipeline until the result has been consumed.
module ex_shift_sequencer #(
    parameter int         XLEN               = 32,
    parameter logic [3:0] ALU_OP_SHIFT_LEFT  = 4'd7,
    parameter logic [3:0] ALU_OP_SHIFT_RIGHT = 4'd8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALU_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] shreg_reg, shreg_next;
    logic [4:0]      cnt_reg, cnt_next;
    logic            dir_reg, dir_next;      // 1 = right, 0 = left

    logic is_shift_op;
    logic accept;
    logic unused_operand_b;

    // Only the low five bits carry the shift amount.
    assign unused_operand_b = ^operand_b[XLEN-1:5];

    assign is_shift_op = (ALU_op == ALU_OP_SHIFT_LEFT) || (ALU_op == ALU_OP_SHIFT_RIGHT);
    assign accept      = (state_reg == IDLE) && in_valid && is_shift_op && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    shreg_next = operand_a;
                    cnt_next   = operand_b[4:0];
                    dir_next   = (ALU_op == ALU_OP_SHIFT_RIGHT);
                    state_next = (operand_b[4:0] == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shreg_next = dir_reg ? (shreg_reg >> 1) : (shreg_reg << 1);
                cnt_next   = cnt_reg - 5'd1;
                if (cnt_reg == 5'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Flush wins over acceptance and over a pending handshake.
        if (flush) begin
            state_next = IDLE;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = shreg_reg;

    // Gated by rst_n so the pipeline is never frozen while held in reset.
    assign stall = rst_n && (accept
                             || (state_reg == SHIFT)
                             || ((state_reg == DONE) && !out_ready));

endmodule

// File: tb/tb_ex_shift_sequencer.sv
// Self-checking bench for ex_shift_sequencer: table of shift operations plus
// hand-written sequences for backpressure, flush and mid-operation reset.
module tb_ex_shift_sequencer;

    localparam logic [3:0] SLL = 4'd7;
    localparam logic [3:0] SRL = 4'd8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALU_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        stall;

    ex_shift_sequencer #(
        .XLEN              (32),
        .ALU_OP_SHIFT_LEFT (SLL),
        .ALU_OP_SHIFT_RIGHT(SRL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ALU_op   (ALU_op),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .stall    (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one shift op with out_ready=1, measure latency and stall cycles.
    task automatic run_op(input int idx, input vec_t v);
        int          lat;
        int          stall_cnt;
        logic [31:0] exp_r;
        in_valid  = 1'b1;
        ALU_op    = v.op;
        operand_a = v.a;
        operand_b = v.b;
        out_ready = 1'b1;
        #1;
        check($sformatf("v%0d accept_ready", idx), {31'd0, in_ready}, 32'd1);
        stall_cnt = stall ? 1 : 0;
        exp_q.push_back(v.exp_result);
        tick();
        in_valid = 1'b0;
        ALU_op   = 4'd0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            if (stall) stall_cnt++;
            tick();
            lat++;
        end
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d stall_cycles", idx), stall_cnt, v.exp_lat);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check($sformatf("v%0d scoreboard_empty", idx), 32'd1, 32'd0);
            end else begin
                exp_r = exp_q.pop_front();
                check($sformatf("v%0d result", idx), result, exp_r);
            end
            check($sformatf("v%0d done_stall", idx), {31'd0, stall}, 32'd0);
        end else begin
            exp_q.delete();
        end
        $display("op %0d: ALU_op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d", idx, v.op, v.a, v.b, result, lat);
        tick();
        check($sformatf("v%0d back_idle", idx), {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] exp_r;

        vecs[0] = '{SLL, 32'h0000_0001, 32'd4,         32'h0000_0010, 5};
        vecs[1] = '{SRL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32};
        vecs[2] = '{SLL, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1};
        vecs[3] = '{SRL, 32'hF0F0_F0F0, 32'd4,         32'h0F0F_0F0F, 5};
        vecs[4] = '{SLL, 32'hFFFF_FFFF, 32'd31,        32'h8000_0000, 32};
        vecs[5] = '{SRL, 32'h1234_5678, 32'd1,         32'h091A_2B3C, 2};
        vecs[6] = '{SLL, 32'h1234_5678, 32'd16,        32'h5678_0000, 17};
        vecs[7] = '{SRL, 32'hDEAD_BEEF, 32'h0000_0024, 32'h0DEA_DBEE, 5};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        ALU_op    = 4'd0;
        operand_a = '0;
        operand_b = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_op(i, vecs[i]);
        end

        // Non-shift opcode is ignored.
        in_valid  = 1'b1;
        ALU_op    = 4'd0;
        operand_a = 32'h5;
        operand_b = 32'h3;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("nonshift ready/valid/stall", {29'd0, in_ready, out_valid, stall}, 32'd4);
            tick();
        end
        in_valid = 1'b0;
        $display("nonshift: ALU_op=0 ignored for 3 cycles");

        // Backpressure: result held while out_ready=0.
        in_valid  = 1'b1;
        ALU_op    = SLL;
        operand_a = 32'h1;
        operand_b = 32'd3;
        out_ready = 1'b0;
        exp_q.push_back(32'h8);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("hold latency", lat, 4);
        exp_r = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hX;
        for (int i = 0; i < 3; i++) begin
            check("hold out_valid/stall", {30'd0, out_valid, stall}, 32'd3);
            check("hold result", result, exp_r);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("hold release stall", {31'd0, stall}, 32'd0);
        tick();
        check("hold back_idle", {30'd0, in_ready, out_valid}, 32'd2);
        $display("hold: SLL 1 by 3 held 3 cycles result=0x%08h", exp_r);

        // Flush at the second SHIFT cycle of a shift by 10.
        in_valid  = 1'b1;
        ALU_op    = SRL;
        operand_a = 32'hFFFF_0000;
        operand_b = 32'd10;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        check("flush shift stall", {31'd0, stall}, 32'd1);
        tick();
        check("flush idle", {30'd0, in_ready, out_valid}, 32'd2);
        in_valid = 1'b1;
        ALU_op   = SLL;
        #1;
        check("flush blocks stall", {31'd0, stall}, 32'd0);
        tick();
        check("flush blocks accept", {30'd0, in_ready, out_valid}, 32'd2);
        flush    = 1'b0;
        in_valid = 1'b0;
        $display("flush: shift by 10 abandoned at second SHIFT cycle");

        // Reset pulsed mid-SHIFT abandons the op.
        in_valid  = 1'b1;
        ALU_op    = SLL;
        operand_a = 32'h3;
        operand_b = 32'd20;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid/stall", {30'd0, out_valid, stall}, 32'd0);
        check("midreset result", result, 32'd0);
        check("midreset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midreset no result", seen, 0);
        $display("reset: shift by 20 abandoned mid-SHIFT");

        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_shift_sequencer.md
EX_SHIFT_SEQUENCER -- requirements
Module: ex_shift_sequencer

Interface
REQ-001 The block SHALL provide parameter XLEN, default 32: operand and result width.
REQ-002 The block SHALL provide parameter ALU_OP_SHIFT_LEFT, default 4'd7: ALU_op code for a logical left shift.
REQ-003 The block SHALL provide parameter ALU_OP_SHIFT_RIGHT, default 4'd8: ALU_op code for a logical right shift.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-005 The block SHALL provide port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-006 The block SHALL provide port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL provide port in_valid, input, 1 bit: the EX stage presents an operation.
REQ-008 The block SHALL provide port in_ready, output, 1 bit: the sequencer can accept an operation.
REQ-009 The block SHALL provide port ALU_op, input, 4 bits: decoded ALU operation code.
REQ-010 The block SHALL provide port operand_a, input, XLEN bits: the value to be shifted.
REQ-011 The block SHALL provide port operand_b, input, XLEN bits: shift amount source; only bits [4:0] are used.
REQ-012 The block SHALL provide port flush, input, 1 bit: synchronous pipeline flush.
REQ-013 The block SHALL provide port out_valid, output, 1 bit: result is available.
REQ-014 The block SHALL provide port out_ready, input, 1 bit: the downstream stage consumes the result.
REQ-015 The block SHALL provide port result, output, XLEN bits: the shifted value.
REQ-016 The block SHALL provide port stall, output, 1 bit: freezes the IF, ID and EX pipeline registers.

Function
REQ-017 The state machine SHALL have three states, IDLE, SHIFT and DONE, encoded in 2 bits.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 An operation is accepted on a rising edge where in_valid=1, in_ready=1, flush=0 and ALU_op equals one of the two shift codes.
REQ-020 When in_valid=1 with any other ALU_op, the block SHALL ignore it and change no state.
REQ-021 On acceptance, the block SHALL load operand_a into the shift register, operand_b[4:0] into a 5-bit counter, and latch the direction.
REQ-022 On acceptance, if operand_b[4:0]=0 the next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-023 In SHIFT, each edge SHALL shift the register by exactly 1 bit and decrement the counter by 1.
REQ-024 Both shift directions SHALL zero-fill.
REQ-025 The block SHALL leave SHIFT for DONE on the edge where the counter decrements from 1 to 0.
REQ-026 Latency for a shift amount N SHALL be N+1 edges from acceptance until out_valid=1; N=0 gives 1 edge and N=31 gives 32 edges.
REQ-027 out_valid SHALL be 1 only in DONE.
REQ-028 result SHALL equal the shift register in DONE and SHALL be held stable while out_ready=0.
REQ-029 In DONE, an edge with out_ready=1 SHALL return the state to IDLE; no new operation can be accepted on that same edge.
REQ-030 stall SHALL be combinational and equal (IDLE and in_valid and a shift op and !flush) OR SHIFT OR (DONE and !out_ready).
REQ-031 flush=1 SHALL force the next state to IDLE from any state, SHALL clear out_valid, and SHALL take priority over acceptance and over out_ready.
REQ-032 The counter SHALL never wrap below 0: in SHIFT a count of 0 is unreachable, and in IDLE and DONE the counter is held.

Reset
REQ-033 While rst_n=0, regardless of clk, the block SHALL hold state=IDLE, shift register=0, counter=0, direction=left, out_valid=0, stall=0 and result=0.
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no result delivered.
REQ-035 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.

Verification
REQ-036 SLL, a=0x00000001, b=4, out_ready=1 -> stall high for 5 cycles, out_valid in the 5th cycle after acceptance, result=0x00000010.
REQ-037 SRL, a=0x80000000, b=0xFFFFFFFF (shift amount 31) -> out_valid 32 edges after acceptance, result=0x00000001.
REQ-038 SLL, a=0xDEADBEEF, b=0x20 (shift amount 0) -> DONE after 1 edge, result=0xDEADBEEF.
REQ-039 ALU_op=4'd0 with in_valid=1 -> in_ready stays 1, stall=0 and out_valid=0 throughout.
REQ-040 SLL, a=0x1, b=3, out_ready held 0 for 3 cycles in DONE -> out_valid and result=0x8 held stable, stall=1; IDLE on the edge after out_ready rises.
REQ-041 Flush at the 2nd SHIFT cycle of a shift by 10 -> IDLE next cycle with out_valid=0; rst_n pulsed low mid-SHIFT -> all outputs 0 immediately.
